// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants and types used by the writeback stage and its neighbours.
package wb_regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/wb_mux.sv
// 2:1 writeback value select; shared with the forwarding unit's MEM/WB source path.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic         sel,
  input  logic [W-1:0] mem_data,
  input  logic [W-1:0] alu_data,
  output logic [W-1:0] wb_data
);

  always_comb begin
    wb_data = sel ? mem_data : alu_data;
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback commit into a 2**ADDR_W-entry register file with two bypassed read ports
// and a wrapping committed-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned n      = DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n_in,
  input  logic              Reg_Write_in,
  input  logic              MemtoReg_in,
  input  logic [n-1:0]      data_memory_output_in,
  input  logic [n-1:0]      ALU_Output_in,
  input  logic [ADDR_W-1:0] MEM_WB_Rd_in,
  input  logic [ADDR_W-1:0] Rs_addr_in,
  input  logic [ADDR_W-1:0] Rt_addr_in,
  output logic [n-1:0]      Rs_data_out,
  output logic [n-1:0]      Rt_data_out,
  output logic [n-1:0]      WB_data_out,
  output logic [CNT_W-1:0]  wb_count_out
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [n-1:0] regs [DEPTH];
  logic         commit;

  wb_mux #(.W(n)) u_wb_mux (
    .sel      (MemtoReg_in),
    .mem_data (data_memory_output_in),
    .alu_data (ALU_Output_in),
    .wb_data  (WB_data_out)
  );

  // An X on Reg_Write_in makes commit X, which the if below treats as false.
  always_comb begin
    commit = Reg_Write_in && (MEM_WB_Rd_in != ZERO_ADDR) && reset_n_in;
  end

  always_ff @(posedge clk or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      wb_count_out <= '0;
    end else if (commit) begin
      regs[MEM_WB_Rd_in] <= WB_data_out;
      wb_count_out       <= wb_count_out + CNT_W'(1);
    end
  end

  always_comb begin
    Rs_data_out = '0;
    if (reset_n_in && (Rs_addr_in != ZERO_ADDR)) begin
      Rs_data_out = (commit && (Rs_addr_in == MEM_WB_Rd_in)) ? WB_data_out : regs[Rs_addr_in];
    end
  end

  always_comb begin
    Rt_data_out = '0;
    if (reset_n_in && (Rt_addr_in != ZERO_ADDR)) begin
      Rt_data_out = (commit && (Rt_addr_in == MEM_WB_Rd_in)) ? WB_data_out : regs[Rt_addr_in];
    end
  end

  a_reg_write_known: assert property (
    @(posedge clk) disable iff (!reset_n_in) !$isunknown(Reg_Write_in)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, reset/wrap sequences,
// then randomized traffic against an array-based architectural model.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  localparam int unsigned CW = 4;

  logic            clk = 1'b0;
  logic            reset_n_in;
  logic            Reg_Write_in;
  logic            MemtoReg_in;
  logic [31:0]     data_memory_output_in;
  logic [31:0]     ALU_Output_in;
  reg_addr_t       MEM_WB_Rd_in;
  reg_addr_t       Rs_addr_in;
  reg_addr_t       Rt_addr_in;
  logic [31:0]     Rs_data_out;
  logic [31:0]     Rt_data_out;
  logic [31:0]     WB_data_out;
  logic [CW-1:0]   wb_count_out;

  wb_regfile #(.n(32), .ADDR_W(5), .CNT_W(CW)) dut (
    .clk                   (clk),
    .reset_n_in            (reset_n_in),
    .Reg_Write_in          (Reg_Write_in),
    .MemtoReg_in           (MemtoReg_in),
    .data_memory_output_in (data_memory_output_in),
    .ALU_Output_in         (ALU_Output_in),
    .MEM_WB_Rd_in          (MEM_WB_Rd_in),
    .Rs_addr_in            (Rs_addr_in),
    .Rt_addr_in            (Rt_addr_in),
    .Rs_data_out           (Rs_data_out),
    .Rt_data_out           (Rt_data_out),
    .WB_data_out           (WB_data_out),
    .wb_count_out          (wb_count_out)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] model_rf [32];
  int unsigned model_cnt;

  typedef struct {
    logic        we;
    logic        m2r;
    logic [31:0] mem;
    logic [31:0] alu;
    reg_addr_t   rd;
    reg_addr_t   rs;
    reg_addr_t   rt;
    logic [31:0] e_wb;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [31:0] mem,
                       input logic [31:0] alu, input reg_addr_t rd,
                       input reg_addr_t rs, input reg_addr_t rt);
    Reg_Write_in          = we;
    MemtoReg_in           = m2r;
    data_memory_output_in = mem;
    ALU_Output_in         = alu;
    MEM_WB_Rd_in          = rd;
    Rs_addr_in            = rs;
    Rt_addr_in            = rt;
  endtask

  task automatic do_reset();
    reset_n_in   = 1'b0;
    Reg_Write_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n_in = 1'b1;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    model_cnt = 0;
  endtask

  // Architectural view: what a reader sees for an address given the pending writeback.
  function automatic logic [31:0] model_read(input int addr, input logic we, input int rd,
                                             input logic [31:0] wb);
    if (addr == 0) return 32'h0;
    if (we && rd != 0 && addr == rd) return wb;
    return model_rf[addr];
  endfunction

  initial begin
    drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
    do_reset();
    #1;
    check("reset_count", 32'(wb_count_out), 32'h0);
    drive(1'b0, 1'b0, '0, '0, '0, 5'd17, 5'd31);
    #1;
    check("reset_rs", Rs_data_out, 32'h0);
    check("reset_rt", Rt_data_out, 32'h0);

    //            we    m2r   mem           alu           rd     rs     rt     e_wb          e_rs          e_rt          cnt
    vecs[0] = '{1'b1, 1'b0, 32'h0,        32'h0000_1234, 5'd7, 5'd7,  5'd0, 32'h1234,     32'h1234,     32'h0,        0};
    vecs[1] = '{1'b0, 1'b1, 32'hCAFE_0001, 32'h1,        5'd9, 5'd7,  5'd9, 32'hCAFE_0001, 32'h1234,    32'h0,        1};
    vecs[2] = '{1'b1, 1'b1, 32'hCAFE_0001, 32'h1,        5'd9, 5'd9,  5'd7, 32'hCAFE_0001, 32'hCAFE_0001, 32'h1234,   1};
    vecs[3] = '{1'b1, 1'b0, 32'h0,        32'h11,        5'd3, 5'd9,  5'd3, 32'h11,       32'hCAFE_0001, 32'h11,      2};
    vecs[4] = '{1'b1, 1'b0, 32'h0,        32'h22,        5'd3, 5'd3,  5'd3, 32'h22,       32'h22,       32'h22,       3};
    vecs[5] = '{1'b0, 1'b0, 32'h0,        32'h99,        5'd3, 5'd3,  5'd3, 32'h99,       32'h22,       32'h22,       4};
    vecs[6] = '{1'b1, 1'b0, 32'h0,        32'hFFFF_FFFF, 5'd0, 5'd0,  5'd0, 32'hFFFF_FFFF, 32'h0,       32'h0,        4};
    vecs[7] = '{1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd0,  5'd3, 32'h0,        32'h0,        32'h22,       4};

    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 drive(vecs[i].we, vecs[i].m2r, vecs[i].mem, vecs[i].alu, vecs[i].rd, vecs[i].rs, vecs[i].rt);
      #1;
      check($sformatf("vec%0d_wb", i), WB_data_out, vecs[i].e_wb);
      check($sformatf("vec%0d_rs", i), Rs_data_out, vecs[i].e_rs);
      check($sformatf("vec%0d_rt", i), Rt_data_out, vecs[i].e_rt);
      check($sformatf("vec%0d_cnt", i), 32'(wb_count_out), vecs[i].e_cnt);
    end
    @(posedge clk);
    #1 drive(1'b0, 1'b0, '0, '0, '0, 5'd0, 5'd9);
    #1;
    check("zero_write_count", 32'(wb_count_out), 32'd4);
    check("r9_after_mux", Rt_data_out, 32'hCAFE_0001);

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #1 drive(1'b1, 1'b0, '0, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, '0, '0, 5'd5, 5'd5, 5'd5);
    #1;
    check("r5_written", Rs_data_out, 32'hDEAD_BEEF);
    #2 reset_n_in = 1'b0;
    #1;
    check("async_rst_rs", Rs_data_out, 32'h0);
    check("async_rst_cnt", 32'(wb_count_out), 32'h0);
    drive(1'b1, 1'b0, '0, 32'h55, 5'd6, 5'd6, 5'd6);
    #1;
    check("rst_held_bypass_rs", Rs_data_out, 32'h0);
    check("rst_held_bypass_rt", Rt_data_out, 32'h0);
    @(posedge clk);
    #1;
    check("rst_held_cnt", 32'(wb_count_out), 32'h0);
    drive(1'b0, 1'b0, '0, '0, '0, 5'd6, 5'd5);
    reset_n_in = 1'b1;
    #1;
    check("rst_held_no_write", Rs_data_out, 32'h0);
    check("rst_cleared_r5", Rt_data_out, 32'h0);

    // Counter wraps modulo 2**CW after 17 commits.
    drive(1'b1, 1'b0, '0, 32'hA5, 5'd1, 5'd1, 5'd1);
    repeat (17) @(posedge clk);
    #1 drive(1'b0, 1'b0, '0, '0, 5'd1, 5'd1, 5'd1);
    #1;
    check("wrap_count", 32'(wb_count_out), 32'd1);
    check("wrap_r1", Rs_data_out, 32'hA5);
    repeat (3) @(posedge clk);
    #1;
    check("idle_count", 32'(wb_count_out), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic        we, m2r;
      logic [31:0] mem, alu, wb;
      int          rd, rs, rt;
      @(posedge clk);
      we  = ($urandom_range(3) != 0);
      m2r = 1'($urandom_range(1));
      mem = $urandom;
      alu = $urandom;
      rd  = $urandom_range(31);
      rs  = ($urandom_range(3) == 0) ? rd : $urandom_range(31);
      rt  = ($urandom_range(3) == 0) ? rs : $urandom_range(31);
      #1 drive(we, m2r, mem, alu, 5'(rd), 5'(rs), 5'(rt));
      #1;
      wb = m2r ? mem : alu;
      check("rnd_wb", WB_data_out, wb);
      check("rnd_rs", Rs_data_out, model_read(rs, we, rd, wb));
      check("rnd_rt", Rt_data_out, model_read(rt, we, rd, wb));
      check("rnd_cnt", 32'(wb_count_out), 32'(model_cnt % (2 ** CW)));
      if (we && rd != 0) begin
        model_rf[rd] = wb;
        model_cnt++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
